// File: rtl/debug_run_ctrl.sv
// Run-control sequencer for the debug CPU: step, burst and continuous run with a
// PC-match breakpoint, plus a count of executed (run) cycles.
module debug_run_ctrl #(
    parameter int unsigned BURST_LEN = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cont_i,
    input  logic        step_p_i,
    input  logic        burst_p_i,
    input  logic        cnt_clr_p_i,
    input  logic        brk_en_i,
    input  logic [31:0] brk_pc_i,
    input  logic [31:0] pc_i,
    output logic        run_o,
    output logic [2:0]  state_o,
    output logic        brk_hit_o,
    output logic [31:0] cycle_cnt_o
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_STEP  = 3'd1,
        ST_CONT  = 3'd2,
        ST_BURST = 3'd3,
        ST_HALT  = 3'd4
    } state_e;

    localparam logic [15:0] BURST_LOAD = 16'(BURST_LEN);

    state_e      state_q, state_d;
    logic [15:0] remaining_q, remaining_d;
    logic        armed_q, armed_d;
    logic [31:0] cycle_cnt_q, cycle_cnt_d;
    logic        bp;
    logic        run;

    // armed is low for the first cycle of CONT/BURST so a resume can execute
    // the instruction sitting at the breakpoint address.
    assign bp = brk_en_i & (pc_i == brk_pc_i) & armed_q;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        armed_d     = armed_q;
        run         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (step_p_i) begin
                    state_d = ST_STEP;
                end else if (burst_p_i) begin
                    state_d     = ST_BURST;
                    remaining_d = BURST_LOAD;
                    armed_d     = 1'b0;
                end else if (cont_i) begin
                    state_d = ST_CONT;
                    armed_d = 1'b0;
                end
            end
            ST_STEP: begin
                run     = 1'b1;
                state_d = ST_IDLE;
            end
            ST_CONT: begin
                armed_d = 1'b1;
                run     = cont_i & ~bp;
                if (bp) begin
                    state_d = ST_HALT;
                end else if (!cont_i) begin
                    state_d = ST_IDLE;
                end
            end
            ST_BURST: begin
                armed_d = 1'b1;
                run     = ~bp;
                if (bp) begin
                    state_d     = ST_HALT;
                    remaining_d = 16'd0;
                end else begin
                    remaining_d = remaining_q - 16'd1;
                    if (remaining_q == 16'd1) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_HALT: begin
                if (step_p_i) begin
                    state_d = ST_STEP;
                end else if (burst_p_i) begin
                    state_d     = ST_BURST;
                    remaining_d = BURST_LOAD;
                    armed_d     = 1'b0;
                end else if (!cont_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Clear wins over a coincident run cycle.
    always_comb begin
        cycle_cnt_d = cycle_cnt_q;
        if (cnt_clr_p_i) begin
            cycle_cnt_d = 32'd0;
        end else if (run) begin
            cycle_cnt_d = cycle_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            remaining_q <= 16'd0;
            armed_q     <= 1'b0;
            cycle_cnt_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            armed_q     <= armed_d;
            cycle_cnt_q <= cycle_cnt_d;
        end
    end

    assign run_o       = run;
    assign state_o     = state_q;
    assign brk_hit_o   = (state_q == ST_HALT);
    assign cycle_cnt_o = cycle_cnt_q;

endmodule
